pipe_scroller: RTL and testbench
================================

# pipe_scroller

Obstacle controller that sits directly downstream of the pipe-height ROM. It owns one pipe and scrolls its X position leftward once per frame. When the pipe leaves the screen it respawns at the right edge; a free-running LFSR picks the ROM index for the new height. It latches the ROM's top-edge Y, derives the bottom edge of the gap, and emits a one-cycle score pulse when the pipe passes the bird column.

## Interface
- SCREEN_W, 640, visible width in pixels
- PIPE_W, 52, pipe width in pixels; SCREEN_W+PIPE_W ≤ 1023
- GAP_H, 120, vertical gap height in pixels
- SPEED, 2, pixels moved per frame_tick (≥1)
- BIRD_X, 160, bird column used for the score pulse
- LFSR_SEED, 8'hA5, LFSR reset value (non-zero)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- run  in  1  game running level
- halt  in  1  collision/game-over level
- rom_idx  out  2  height-ROM address, registered
- rom_y  in  8  ROM top edge of gap (combinational from rom_idx)
- pipe_x  out  10  pipe right edge, pixels
- gap_top  out  8  latched top edge of gap
- gap_bot  out  9  gap_top + GAP_H
- pipe_valid  out  1  pipe geometry valid for draw/collision
- passed  out  1  one-cycle score pulse

## Operation
- Reset values: state IDLE, lfsr=LFSR_SEED, rom_idx=0, pipe_x=SCREEN_W+PIPE_W (SPAWN), gap_top=0, gap_bot=0, pipe_valid=0, passed=0.
- LFSR: 8-bit Fibonacci, advances every clk while out of reset. fb = l[7]^l[5]^l[4]^l[3]; next = {l[6:0], fb}.
- States: IDLE, LOAD, RUN, HALT.
- IDLE:
  - Holds pipe_x=SPAWN and pipe_valid=0.
  - If run=1: rom_idx <= lfsr_next[1:0], go to LOAD.
- LOAD (exactly 1 cycle):
  - gap_top <= rom_y; gap_bot <= {1'b0,rom_y}+GAP_H (9-bit, no overflow for rom_y ≤ 255, GAP_H ≤ 256).
  - pipe_valid <= 1; go to RUN.
  - frame_tick in this cycle is dropped.
- RUN, on frame_tick:
  - If pipe_x ≤ SPEED (respawn): pipe_x <= SPAWN, rom_idx <= lfsr_next[1:0], pipe_valid <= 0, go to LOAD.
  - Else: pipe_x <= pipe_x − SPEED.
  - passed <= 1 iff old pipe_x ≥ BIRD_X and new pipe_x < BIRD_X.
- HALT:
  - All outputs frozen; passed forced 0.
  - Exits only to IDLE when run=0. Deasserting halt alone does not resume.
- Priority each cycle: run=0 (→ IDLE from any state, pipe_valid <= 0) > halt=1 (RUN/LOAD → HALT) > frame_tick.
- A LOAD interrupted by halt still completes its latch into gap_top/gap_bot before HALT.

## Timing
- rom_idx is registered; rom_y is sampled one cycle later in LOAD. Total ROM latency budget is one clk.
- pipe_valid is low for exactly one cycle (LOAD) on every spawn/respawn.
- passed is high for a single clk, coincident with the pipe_x update that crosses BIRD_X.
- pipe_x changes only on the clk edge where frame_tick=1 in RUN, or on entry to IDLE/respawn.
- Asynchronous reset mid-scroll returns immediately to the reset values. The LFSR restarts from LFSR_SEED.
- With defaults, 692→2 takes 345 ticks; the 346th tick respawns. passed fires on tick 267 (pipe_x 160→158).

## Test plan
- Reset, release, run=1 at first edge → lfsr 8'h4A, rom_idx=2'b10; with ROM model returning 200: gap_top=200, gap_bot=320, pipe_valid=1 one cycle later, pipe_x=692.
- 345 frame_ticks in RUN → pipe_x=2, no respawn. Tick 346 → pipe_x=692, pipe_valid=0 for 1 cycle, rom_idx matches LFSR model, new gap latched.
- Tick sweep → passed high exactly once per pipe pass, on the 267th tick (pipe_x=158), never during HALT.
- halt=1 together with frame_tick at pipe_x=400 → pipe_x stays 400 and state is HALT. Dropping halt leaves it frozen; run=0 → IDLE, pipe_x=692, pipe_valid=0.
- rst_n pulsed low mid-scroll (pipe_x=300) → all outputs take their reset values asynchronously, before the next clk edge.
- frame_tick asserted in the LOAD cycle → ignored; pipe_x unchanged until the next tick.

Source files
------------

// File: rtl/pipe_scroller.sv
// Single-pipe obstacle controller: scrolls the pipe left once per frame, respawns it
// at the right edge with an LFSR-chosen ROM height, and pulses "passed" at the bird column.
module pipe_scroller #(
    parameter int          SCREEN_W  = 640,
    parameter int          PIPE_W    = 52,
    parameter int          GAP_H     = 120,
    parameter int          SPEED     = 2,
    parameter int          BIRD_X    = 160,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       run,
    input  logic       halt,
    output logic [1:0] rom_idx,
    input  logic [7:0] rom_y,
    output logic [9:0] pipe_x,
    output logic [7:0] gap_top,
    output logic [8:0] gap_bot,
    output logic       pipe_valid,
    output logic       passed
);

    localparam logic [9:0] SPAWN = 10'(SCREEN_W + PIPE_W);
    localparam logic [9:0] SPD   = 10'(SPEED);
    localparam logic [9:0] BX    = 10'(BIRD_X);
    localparam logic [8:0] GAP   = 9'(GAP_H);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

    state_t     state, state_d;
    logic [7:0] lfsr, lfsr_next;
    logic [1:0] rom_idx_d;
    logic [9:0] pipe_x_d, x_step;
    logic [7:0] gap_top_d;
    logic [8:0] gap_bot_d;
    logic       valid_d, passed_d;

    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign x_step    = pipe_x - SPD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr       <= LFSR_SEED;
            rom_idx    <= '0;
            pipe_x     <= SPAWN;
            gap_top    <= '0;
            gap_bot    <= '0;
            pipe_valid <= 1'b0;
            passed     <= 1'b0;
        end else begin
            lfsr       <= lfsr_next;
            rom_idx    <= rom_idx_d;
            pipe_x     <= pipe_x_d;
            gap_top    <= gap_top_d;
            gap_bot    <= gap_bot_d;
            pipe_valid <= valid_d;
            passed     <= passed_d;
        end
    end

    always_comb begin
        state_d   = state;
        rom_idx_d = rom_idx;
        pipe_x_d  = pipe_x;
        gap_top_d = gap_top;
        gap_bot_d = gap_bot;
        valid_d   = pipe_valid;
        passed_d  = 1'b0;

        case (state)
            IDLE: begin
                pipe_x_d = SPAWN;
                valid_d  = 1'b0;
                if (run) begin
                    rom_idx_d = lfsr_next[1:0];
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (!run) begin
                    state_d  = IDLE;
                    pipe_x_d = SPAWN;
                    valid_d  = 1'b0;
                end else begin
                    // latch completes even when halt arrives in this cycle
                    gap_top_d = rom_y;
                    gap_bot_d = {1'b0, rom_y} + GAP;
                    valid_d   = 1'b1;
                    state_d   = halt ? HALT : RUN;
                end
            end
            RUN: begin
                if (!run) begin
                    state_d  = IDLE;
                    pipe_x_d = SPAWN;
                    valid_d  = 1'b0;
                end else if (halt) begin
                    state_d = HALT;
                end else if (frame_tick) begin
                    if (pipe_x <= SPD) begin
                        pipe_x_d  = SPAWN;
                        rom_idx_d = lfsr_next[1:0];
                        valid_d   = 1'b0;
                        state_d   = LOAD;
                    end else begin
                        pipe_x_d = x_step;
                        passed_d = (pipe_x >= BX) && (x_step < BX);
                    end
                end
            end
            HALT: begin
                if (!run) begin
                    state_d  = IDLE;
                    pipe_x_d = SPAWN;
                    valid_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pipe_scroller.sv
// Bench for pipe_scroller: directed scenarios plus randomized run/halt/tick traffic,
// checked every cycle against a behavioural model of the pipe's motion and respawn rules.
module tb_pipe_scroller;

    localparam int         SCREEN_W  = 640;
    localparam int         PIPE_W    = 52;
    localparam int         GAP_H     = 120;
    localparam int         SPEED     = 2;
    localparam int         BIRD_X    = 160;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam int         SPAWN     = SCREEN_W + PIPE_W;

    localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_HALT = 3;

    logic       clk = 1'b0;
    logic       rst_n, frame_tick, run, halt;
    logic [1:0] rom_idx;
    logic [7:0] rom_y;
    logic [9:0] pipe_x;
    logic [7:0] gap_top;
    logic [8:0] gap_bot;
    logic       pipe_valid, passed;

    logic [7:0] rom_tab [4] = '{8'd40, 8'd100, 8'd200, 8'd135};
    assign rom_y = rom_tab[rom_idx];

    pipe_scroller #(
        .SCREEN_W (SCREEN_W),
        .PIPE_W   (PIPE_W),
        .GAP_H    (GAP_H),
        .SPEED    (SPEED),
        .BIRD_X   (BIRD_X),
        .LFSR_SEED(LFSR_SEED)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_tick(frame_tick),
        .run       (run),
        .halt      (halt),
        .rom_idx   (rom_idx),
        .rom_y     (rom_y),
        .pipe_x    (pipe_x),
        .gap_top   (gap_top),
        .gap_bot   (gap_bot),
        .pipe_valid(pipe_valid),
        .passed    (passed)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int         m_phase, m_x, m_idx, m_top, m_bot, m_valid, m_passed;
    logic [7:0] m_lfsr;

    int pass_cnt, pass_tick, tick_no;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_x = SPAWN; m_idx = 0; m_top = 0; m_bot = 0;
        m_valid = 0; m_passed = 0; m_lfsr = LFSR_SEED;
    endtask

    // one rising edge of the game rules, using the inputs the DUT just sampled
    task automatic model_step();
        logic [7:0] nxt;
        int old_x;
        if (!rst_n) begin
            model_reset();
            return;
        end
        nxt = lfsr_step(m_lfsr);
        m_passed = 0;
        if (m_phase == P_IDLE) begin
            if (run) begin
                m_idx = int'(nxt[1:0]);
                m_phase = P_LOAD;
            end
        end else if (!run) begin
            m_phase = P_IDLE; m_x = SPAWN; m_valid = 0;
        end else if (m_phase == P_LOAD) begin
            m_top = rom_tab[m_idx];
            m_bot = m_top + GAP_H;
            m_valid = 1;
            m_phase = halt ? P_HALT : P_RUN;
        end else if (m_phase == P_RUN) begin
            if (halt) m_phase = P_HALT;
            else if (frame_tick) begin
                old_x = m_x;
                if (old_x <= SPEED) begin
                    m_x = SPAWN; m_idx = int'(nxt[1:0]); m_valid = 0; m_phase = P_LOAD;
                end else begin
                    m_x = old_x - SPEED;
                    m_passed = (old_x >= BIRD_X && m_x < BIRD_X) ? 1 : 0;
                end
            end
        end
        m_lfsr = nxt;
    endtask

    task automatic compare_all();
        check("rom_idx",    int'(rom_idx),    m_idx);
        check("pipe_x",     int'(pipe_x),     m_x);
        check("gap_top",    int'(gap_top),    m_top);
        check("gap_bot",    int'(gap_bot),    m_bot);
        check("pipe_valid", int'(pipe_valid), m_valid);
        check("passed",     int'(passed),     m_passed);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
        tick_no++;
        if (passed) begin
            pass_cnt++;
            pass_tick = tick_no;
        end
        cycle();
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; halt = 1'b0; frame_tick = 1'b0;
        model_reset();
        cycle();
        cycle();
        check("reset_pipe_x", int'(pipe_x), 692);
        check("reset_valid",  int'(pipe_valid), 0);

        // first edge out of reset already has run=1
        rst_n = 1'b1; run = 1'b1;
        cycle();
        check("first_rom_idx", int'(rom_idx), 2);
        check("model_lfsr",    int'(m_lfsr), 8'h4A);
        check("first_pipe_x",  int'(pipe_x), 692);
        cycle();
        check("load_gap_top", int'(gap_top), 200);
        check("load_gap_bot", int'(gap_bot), 320);
        check("load_valid",   int'(pipe_valid), 1);

        pass_cnt = 0; pass_tick = 0; tick_no = 0;
        for (int t = 0; t < 345; t++) tick();
        check("x_after_345",   int'(pipe_x), 2);
        check("pass_count",    pass_cnt, 1);
        check("pass_tick_no",  pass_tick, 267);

        // tick 346 respawns; a tick during LOAD is dropped
        frame_tick = 1'b1;
        cycle();
        check("respawn_x",     int'(pipe_x), 692);
        check("respawn_valid", int'(pipe_valid), 0);
        cycle();
        check("load_tick_x",     int'(pipe_x), 692);
        check("load_tick_valid", int'(pipe_valid), 1);
        frame_tick = 1'b0;
        cycle();
        check("load_hold_x", int'(pipe_x), 692);
        tick();
        check("post_load_tick_x", int'(pipe_x), 690);

        for (int t = 0; t < 145; t++) tick();
        check("x_at_400", int'(pipe_x), 400);
        pass_cnt = 0;
        halt = 1'b1; frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
        check("halt_x", int'(pipe_x), 400);
        halt = 1'b0;
        for (int t = 0; t < 3; t++) tick();
        check("halt_frozen_x", int'(pipe_x), 400);
        check("halt_no_pass",  pass_cnt, 0);
        run = 1'b0;
        cycle();
        check("idle_x",     int'(pipe_x), 692);
        check("idle_valid", int'(pipe_valid), 0);

        run = 1'b1;
        cycle();
        cycle();
        for (int t = 0; t < 196; t++) tick();
        check("x_at_300", int'(pipe_x), 300);

        // asynchronous reset between edges
        rst_n = 1'b0;
        #1;
        check("async_pipe_x",  int'(pipe_x), 692);
        check("async_valid",   int'(pipe_valid), 0);
        check("async_gap_top", int'(gap_top), 0);
        check("async_gap_bot", int'(gap_bot), 0);
        check("async_rom_idx", int'(rom_idx), 0);
        check("async_passed",  int'(passed), 0);
        model_reset();
        cycle();
        rst_n = 1'b1;
        cycle();
        check("restart_rom_idx", int'(rom_idx), 2);

        for (int c = 0; c < 4000; c++) begin
            frame_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) < 2) halt = ~halt;
            if (run && $urandom_range(0, 299) < 2) run = 1'b0;
            else if (!run && $urandom_range(0, 9) == 0) run = 1'b1;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
